// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: idle/scan/blink/fill modes paced by a programmable tick divider.
// Optional LED_PATTERN_DIM_EN adds a dim_level input and 16-step PWM gating of led_out.
module led_pattern_sequencer #(
  parameter int WIDTH      = 8,
  parameter int CNT_W      = 22,
  parameter int BASE_COUNT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode_sel,
  input  logic             mode_load,
  input  logic             speed_up,
  input  logic             speed_down,
  input  logic             pause,
`ifdef LED_PATTERN_DIM_EN
  input  logic [1:0]       dim_level,
`endif
  output logic [WIDTH-1:0] led_out,
  output logic             mode_ack,
  output logic             tick
);

  typedef enum logic [2:0] {S_IDLE, S_SCAN_R, S_SCAN_L, S_BLINK, S_FILL} state_t;

  localparam logic [CNT_W-1:0] BASE = CNT_W'(BASE_COUNT);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_pat, w_pat_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_speed, w_speed_nxt;
  logic             r_pend, w_pend_nxt;
  logic [1:0]       r_pend_mode, w_pend_mode_nxt;
  logic             r_tick, r_ack;
  logic             w_tick, w_ack;
  logic [CNT_W-1:0] w_last;
  logic [WIDTH-1:0] w_shr, w_shl, w_fill;

  assign w_last = (BASE << r_speed) - CNT_W'(1);
  assign w_shr  = {1'b0, r_pat[WIDTH-1:1]};
  assign w_shl  = {r_pat[WIDTH-2:0], 1'b0};
  assign w_fill = (&r_pat) ? '0 : {1'b1, r_pat[WIDTH-1:1]};

  always_comb begin
    w_state_nxt     = r_state;
    w_pat_nxt       = r_pat;
    w_cnt_nxt       = r_cnt;
    w_speed_nxt     = r_speed;
    w_pend_nxt      = r_pend;
    w_pend_mode_nxt = r_pend_mode;
    w_tick          = 1'b0;
    w_ack           = 1'b0;

    // A lone speed pulse restarts the period instead of ticking; both together cancel.
    if (!pause) begin
      if (speed_up ^ speed_down) begin
        w_cnt_nxt = '0;
        if (speed_up && r_speed != 3'd0)
          w_speed_nxt = r_speed - 3'd1;
        else if (speed_down && r_speed != 3'd7)
          w_speed_nxt = r_speed + 3'd1;
      end else if (r_cnt == w_last) begin
        w_cnt_nxt = '0;
        w_tick    = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end

    if (w_tick) begin
      if (r_pend) begin
        w_ack      = 1'b1;
        w_pend_nxt = 1'b0;
        case (r_pend_mode)
          2'd0:    begin w_state_nxt = S_IDLE;   w_pat_nxt = '0; end
          2'd1:    begin w_state_nxt = S_SCAN_R; w_pat_nxt = {1'b1, {(WIDTH-1){1'b0}}}; end
          2'd2:    begin w_state_nxt = S_BLINK;  w_pat_nxt = '1; end
          default: begin w_state_nxt = S_FILL;   w_pat_nxt = '0; end
        endcase
      end else begin
        case (r_state)
          S_SCAN_R: begin
            w_pat_nxt = w_shr;
            if (w_shr[0]) w_state_nxt = S_SCAN_L;
          end
          S_SCAN_L: begin
            w_pat_nxt = w_shl;
            if (w_shl[WIDTH-1]) w_state_nxt = S_SCAN_R;
          end
          S_BLINK:  w_pat_nxt = (r_pat == '0) ? '1 : '0;
          S_FILL:   w_pat_nxt = w_fill;
          default:  w_pat_nxt = '0;
        endcase
      end
    end

    // A load in a tick cycle lands after the apply above, so it waits for the next tick.
    if (mode_load) begin
      w_pend_nxt      = 1'b1;
      w_pend_mode_nxt = mode_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pat       <= '0;
      r_cnt       <= '0;
      r_speed     <= '0;
      r_pend      <= 1'b0;
      r_pend_mode <= '0;
      r_tick      <= 1'b0;
      r_ack       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pat       <= w_pat_nxt;
      r_cnt       <= w_cnt_nxt;
      r_speed     <= w_speed_nxt;
      r_pend      <= w_pend_nxt;
      r_pend_mode <= w_pend_mode_nxt;
      r_tick      <= w_tick;
      r_ack       <= w_ack;
    end
  end

  assign tick     = r_tick;
  assign mode_ack = r_ack;

`ifdef LED_PATTERN_DIM_EN
  logic [3:0] r_pwm;
  logic [4:0] w_thr;
  logic       w_on;

  always_ff @(posedge clk) begin
    if (rst) r_pwm <= '0;
    else     r_pwm <= r_pwm + 4'd1;
  end

  // Duty is 4*(dim_level+1) of every 16 clocks.
  assign w_thr   = {1'b0, dim_level, 2'b00} + 5'd4;
  assign w_on    = ({1'b0, r_pwm} < w_thr);
  assign led_out = r_pat & {WIDTH{w_on}};
`else
  assign led_out = r_pat;
`endif

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: vector table, directed corner sequences and a
// random run checked cycle-by-cycle against a mode/step reference model.
module tb_led_pattern_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode_sel = '0;
  logic       mode_load = 1'b0, speed_up = 1'b0, speed_down = 1'b0, pause = 1'b0;
  logic [7:0] led_out;
  logic       mode_ack, tick;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  led_pattern_sequencer #(.WIDTH(8), .CNT_W(22), .BASE_COUNT(4)) dut (
    .clk(clk), .rst(rst), .mode_sel(mode_sel), .mode_load(mode_load),
    .speed_up(speed_up), .speed_down(speed_down), .pause(pause),
    .led_out(led_out), .mode_ack(mode_ack), .tick(tick)
  );

  // Reference model: a mode number plus a step index into that mode's cyclic sequence.
  int         m_cnt = 0, m_speed = 0, m_mode = 0, m_step = 0, m_pmode = 0;
  bit         m_pend = 0;
  logic [7:0] m_led = '0;
  logic       m_tick = 1'b0, m_ack = 1'b0;

  function automatic int seq_len(int mode);
    case (mode)
      1: return 14;
      2: return 2;
      3: return 9;
      default: return 1;
    endcase
  endfunction

  function automatic logic [7:0] pat(int mode, int step);
    logic [7:0] ones;
    int pos;
    ones = 8'hFF;
    case (mode)
      1: begin
        pos = (step <= 7) ? 7 - step : step - 7;
        return 8'(1 << pos);
      end
      2: return (step % 2 == 0) ? ones : 8'h00;
      3: return (step == 0) ? 8'h00 : 8'(ones << (8 - step));
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    bit t;
    if (rst) begin
      m_cnt = 0; m_speed = 0; m_mode = 0; m_step = 0; m_pend = 0;
      m_led = '0; m_tick = 0; m_ack = 0;
    end else begin
      t = 0;
      m_ack = 0;
      if (!pause) begin
        if (speed_up != speed_down) begin
          if (speed_up && m_speed > 0) m_speed--;
          if (speed_down && m_speed < 7) m_speed++;
          m_cnt = 0;
        end else if (m_cnt == (4 << m_speed) - 1) begin
          m_cnt = 0;
          t = 1;
        end else begin
          m_cnt++;
        end
      end
      if (t) begin
        if (m_pend) begin
          m_mode = m_pmode; m_step = 0; m_pend = 0; m_ack = 1;
        end else begin
          m_step = (m_step + 1) % seq_len(m_mode);
        end
      end
      if (mode_load) begin
        m_pend = 1;
        m_pmode = int'(mode_sel);
      end
      m_led = pat(m_mode, m_step);
      m_tick = t;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    chk("model_led", 32'(led_out), 32'(m_led));
    chk("model_tick", 32'(tick), 32'(m_tick));
    chk("model_ack", 32'(mode_ack), 32'(m_ack));
  endtask

  task automatic clear_in();
    rst = 0; mode_load = 0; speed_up = 0; speed_down = 0; pause = 0;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (tick !== 1'b1 && n < 2000);
    if (tick !== 1'b1) begin
      n_chk++;
      n_fail++;
      $display("FAIL tick_timeout: no tick within %0d cycles", n);
    end
  endtask

  typedef struct {
    logic       rst;
    logic [1:0] msel;
    logic       ld;
    logic       su, sd, pz;
    logic [7:0] led;
    logic       tk, ak;
  } vec_t;

  vec_t vt[13];
  logic [7:0] scan_exp[15];
  logic [7:0] fill_exp[9];

  initial begin
    int n;

    vt[0]  = '{1, 2'd0, 0, 0, 0, 0, 8'h00, 0, 0};
    vt[1]  = '{0, 2'd1, 1, 0, 0, 0, 8'h00, 0, 0};
    vt[2]  = '{0, 2'd0, 0, 0, 0, 0, 8'h00, 0, 0};
    vt[3]  = '{0, 2'd0, 0, 0, 0, 0, 8'h00, 0, 0};
    vt[4]  = '{0, 2'd0, 0, 0, 0, 0, 8'h80, 1, 1};
    vt[5]  = '{0, 2'd0, 0, 0, 0, 0, 8'h80, 0, 0};
    vt[6]  = '{0, 2'd0, 0, 0, 0, 0, 8'h80, 0, 0};
    vt[7]  = '{0, 2'd0, 0, 0, 0, 0, 8'h80, 0, 0};
    vt[8]  = '{0, 2'd0, 0, 0, 0, 0, 8'h40, 1, 0};
    vt[9]  = '{0, 2'd0, 0, 0, 0, 1, 8'h40, 0, 0};
    vt[10] = '{0, 2'd0, 0, 0, 0, 0, 8'h40, 0, 0};
    vt[11] = '{0, 2'd0, 0, 0, 0, 0, 8'h40, 0, 0};
    vt[12] = '{0, 2'd0, 0, 0, 0, 0, 8'h40, 0, 0};
    scan_exp = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02,
                 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40};
    fill_exp = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF, 8'h00};

    rst = 1;
    cyc();
    cyc();

    // Vector table: reset, SCAN entry after 4 cycles, one-cycle pause delaying a tick.
    for (int i = 0; i < 13; i++) begin
      rst = vt[i].rst; mode_sel = vt[i].msel; mode_load = vt[i].ld;
      speed_up = vt[i].su; speed_down = vt[i].sd; pause = vt[i].pz;
      cyc();
      chk($sformatf("vec%0d_led", i), 32'(led_out), 32'(vt[i].led));
      chk($sformatf("vec%0d_tick", i), 32'(tick), 32'(vt[i].tk));
      chk($sformatf("vec%0d_ack", i), 32'(mode_ack), 32'(vt[i].ak));
    end
    clear_in();

    // Reset mid-SCAN, then first tick 4 cycles after release.
    for (int i = 0; i < 3; i++) begin
      rst = 1;
      cyc();
      chk("rst_led", 32'(led_out), 32'h0);
      chk("rst_tick", 32'(tick), 32'h0);
      chk("rst_ack", 32'(mode_ack), 32'h0);
    end
    rst = 0;
    wait_tick(n);
    chk("rst_first_tick_dist", 32'(n), 32'd4);

    // Full scan cycle with 4-cycle spacing.
    mode_sel = 2'd1; mode_load = 1;
    cyc();
    mode_load = 0;
    wait_tick(n);
    chk("scan_entry_led", 32'(led_out), 32'h80);
    chk("scan_entry_ack", 32'(mode_ack), 32'h1);
    for (int i = 0; i < 15; i++) begin
      wait_tick(n);
      chk($sformatf("scan%0d_led", i), 32'(led_out), 32'(scan_exp[i]));
      chk("scan_spacing", 32'(n), 32'd4);
    end

    // Speed: two slow-downs, saturation at 512, simultaneous pulses ignored.
    speed_down = 1; cyc(); cyc(); speed_down = 0;
    wait_tick(n);
    chk("speed2_first", 32'(n), 32'd16);
    wait_tick(n);
    chk("speed2_period", 32'(n), 32'd16);
    speed_down = 1;
    for (int i = 0; i < 10; i++) cyc();
    speed_down = 0;
    wait_tick(n);
    chk("speed_sat_first", 32'(n), 32'd512);
    speed_up = 1; speed_down = 1;
    cyc();
    speed_up = 0; speed_down = 0;
    wait_tick(n);
    chk("speed_both_period", 32'(n + 1), 32'd512);

    // Request overwrite: BLINK replaced by FILL before the tick, single ack.
    rst = 1; cyc(); rst = 0;
    mode_sel = 2'd2; mode_load = 1; cyc();
    mode_sel = 2'd3; cyc();
    mode_load = 0;
    wait_tick(n);
    chk("ovr_led", 32'(led_out), 32'h00);
    chk("ovr_ack", 32'(mode_ack), 32'h1);
    chk("ovr_latency", 32'(n), 32'd2);
    for (int i = 0; i < 9; i++) begin
      wait_tick(n);
      chk($sformatf("fill%0d_led", i), 32'(led_out), 32'(fill_exp[i]));
      chk("fill_no_ack", 32'(mode_ack), 32'h0);
    end

    // Pause during BLINK with a SCAN load pending.
    mode_sel = 2'd2; mode_load = 1; cyc(); mode_load = 0;
    wait_tick(n);
    chk("blink_entry", 32'(led_out), 32'hFF);
    cyc();
    mode_sel = 2'd1; mode_load = 1; pause = 1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      mode_load = 0;
      chk("pause_led", 32'(led_out), 32'hFF);
      chk("pause_tick", 32'(tick), 32'h0);
      chk("pause_ack", 32'(mode_ack), 32'h0);
    end
    pause = 0;
    wait_tick(n);
    chk("pause_resume_dist", 32'(n), 32'd3);
    chk("pause_resume_ack", 32'(mode_ack), 32'h1);
    chk("pause_resume_led", 32'(led_out), 32'h80);

    // Random run against the model.
    for (int i = 0; i < 4000; i++) begin
      rst        = ($urandom % 400 == 0);
      mode_load  = ($urandom % 8 == 0);
      mode_sel   = 2'($urandom);
      speed_up   = ($urandom % 25 == 0);
      speed_down = ($urandom % 40 == 0);
      if ($urandom % 25 == 0) pause = ~pause;
      cyc();
    end
    clear_in();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
